// File: rtl/v60_pkg.sv
// Shared definitions for the V60 memory-port arbiter: bus widths, access
// size encodings and the arbiter state type.
package v60_pkg;

  localparam int V60_ADDR_WIDTH = 32;
  localparam int V60_DATA_WIDTH = 32;

  // Access size encodings carried on size_i / mem_size
  localparam logic [1:0] V60_SIZE_BYTE = 2'b00;
  localparam logic [1:0] V60_SIZE_HALF = 2'b01;
  localparam logic [1:0] V60_SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/v60_arb_pick.sv
// Combinational winner selection for the V60 bus arbiter.
// Build option V60_ARB_RR_EN: when defined, round-robin search starting at
// 'start'; when undefined, fixed priority with the lowest index winning and
// 'start' ignored.
module v60_arb_pick
  import v60_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         start,
  output logic               valid,
  output logic [2:0]         idx
);

  assign valid = |req;

`ifdef V60_ARB_RR_EN
  logic [NUM_REQ-1:0] rot_s;
  logic [2:0]         off_s;
  logic [3:0]         sum_s;

  // Rotate so the search origin sits at bit 0; the doubled copy makes the wrap free
  assign rot_s = NUM_REQ'({req, req} >> start);

  // Lowest set bit of the rotated vector is the distance from the origin
  always_comb begin
    off_s = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? 3'(i) : off_s;
    end
  end

  // Map the distance back to an absolute requester index, modulo NUM_REQ
  always_comb begin
    sum_s = {1'b0, start} + {1'b0, off_s};
    if (sum_s >= 4'(NUM_REQ)) begin
      idx = 3'(sum_s - 4'(NUM_REQ));
    end else begin
      idx = sum_s[2:0];
    end
  end
`else
  logic start_unused_s;
  assign start_unused_s = ^start;

  // Fixed priority: scanning downwards leaves the lowest requesting index
  always_comb begin
    idx = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = req[i] ? 3'(i) : idx;
    end
  end
`endif

endmodule

// File: rtl/v60_bus_arbiter.sv
// V60 memory-port arbiter: grants one of NUM_REQ requesters (0=fetch,
// 1=data, 2=DMA), drives the registered memory request, returns
// ready/rdata to the owner and aborts a hung access with err_o after
// TIMEOUT_CYCLES cycles.
// Build option V60_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority, lowest index first).
module v60_bus_arbiter
  import v60_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 wr_i,
  input  logic [2*NUM_REQ-1:0]               size_i,
  input  logic [NUM_REQ*V60_ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*V60_DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]                 ready_o,
  output logic [NUM_REQ-1:0]                 err_o,
  output logic [V60_DATA_WIDTH-1:0]          rdata_o,
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [1:0]                         mem_size,
  output logic [V60_ADDR_WIDTH-1:0]          mem_addr,
  output logic [V60_DATA_WIDTH-1:0]          mem_wdata,
  input  logic [V60_DATA_WIDTH-1:0]          mem_rdata,
  input  logic                               mem_ready,
  output logic [2:0]                         owner_o,
  output logic                               busy_o
);

  localparam logic [0:0]  ST_IDLE  = 1'(ARB_IDLE);
  localparam logic [0:0]  ST_BUSY  = 1'(ARB_BUSY);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [0:0]                state_r;
  logic [0:0]                state_nxt_s;
  logic [15:0]               cnt_r;
  logic [15:0]               cnt_nxt_s;
  logic [2:0]                owner_r;
  logic                      mem_req_r;
  logic                      mem_wr_r;
  logic [1:0]                mem_size_r;
  logic [V60_ADDR_WIDTH-1:0] mem_addr_r;
  logic [V60_DATA_WIDTH-1:0] mem_wdata_r;

  logic                      busy_s;
  logic                      done_s;
  logic                      tmo_s;
  logic                      grant_s;
  logic [NUM_REQ-1:0]        owner_oh_s;
  logic [NUM_REQ-1:0]        pick_req_s;
  logic [2:0]                pick_start_s;
  logic                      pick_valid_s;
  logic [2:0]                pick_idx_s;
  logic                      sel_wr_s;
  logic [1:0]                sel_size_s;
  logic [V60_ADDR_WIDTH-1:0] sel_addr_s;
  logic [V60_DATA_WIDTH-1:0] sel_wdata_s;

  assign busy_s = (state_r == ST_BUSY);
  // A completion beats a timeout that lands in the same cycle
  assign done_s = busy_s & mem_ready;
  assign tmo_s  = busy_s & ~mem_ready & (cnt_r == TMO_LAST);

  // One-hot decode of the current owner
  always_comb begin
    owner_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh_s[i] = (owner_r == 3'(i));
    end
  end

  assign ready_o = (done_s | tmo_s) ? owner_oh_s : '0;
  assign err_o   = tmo_s ? owner_oh_s : '0;
  assign rdata_o = (done_s | tmo_s) ? mem_rdata : '0;

  // In BUSY the finishing owner must not win its own back-to-back slot
  assign pick_req_s = busy_s ? (req_i & ~owner_oh_s) : req_i;

`ifdef V60_ARB_RR_EN
  logic [2:0] ptr_r;

  // Round-robin origin: one past the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 3'd0;
    end else if (grant_s) begin
      ptr_r <= (pick_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : (pick_idx_s + 3'd1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign pick_start_s = ptr_r;
`else
  assign pick_start_s = 3'd0;
`endif

  v60_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (pick_req_s),
    .start (pick_start_s),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // New grants only happen from IDLE or on a normal completion, never on timeout
  assign grant_s = pick_valid_s & (~busy_s | done_s);

  // Mux the winning requester's transaction fields
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_size_s  = 2'b00;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_wr_s    = (pick_idx_s == 3'(i)) ? wr_i[i]                                     : sel_wr_s;
      sel_size_s  = (pick_idx_s == 3'(i)) ? size_i[i*2 +: 2]                            : sel_size_s;
      sel_addr_s  = (pick_idx_s == 3'(i)) ? addr_i[i*V60_ADDR_WIDTH +: V60_ADDR_WIDTH]  : sel_addr_s;
      sel_wdata_s = (pick_idx_s == 3'(i)) ? wdata_i[i*V60_DATA_WIDTH +: V60_DATA_WIDTH] : sel_wdata_s;
    end
  end

  // Next state and timeout counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 16'd0;
        if (pick_valid_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          cnt_nxt_s = 16'd0;
          if (pick_valid_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (tmo_s) begin
          cnt_nxt_s   = 16'd0;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r + 16'd1;
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        cnt_nxt_s   = 16'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, request strobe and latched owner/transaction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      mem_req_r   <= 1'b0;
      owner_r     <= 3'd0;
      mem_wr_r    <= 1'b0;
      mem_size_r  <= 2'b00;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mem_req_r <= (state_nxt_s == ST_BUSY);
      if (grant_s) begin
        owner_r     <= pick_idx_s;
        mem_wr_r    <= sel_wr_s;
        mem_size_r  <= sel_size_s;
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
      end else begin
        owner_r     <= owner_r;
        mem_wr_r    <= mem_wr_r;
        mem_size_r  <= mem_size_r;
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_wr    = mem_wr_r;
  assign mem_size  = mem_size_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign owner_o   = owner_r;
  assign busy_o    = busy_s;

endmodule
